// File: rtl/dsram_axi_bridge.sv
// dsram_axi_bridge
// Turns each access on the core's data SRAM port into one single-beat
// AXI-style read or write transaction. While that transaction is in flight
// it asserts stallreq so the pipeline holds. Read data is then presented
// the way a synchronous SRAM would present it.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   data_sram_en/wen/addr/wdata   core request (wen==0 means read)
//   data_sram_rdata     last completed read data (ERR_DATA on a read error)
//   stallreq            hold the pipeline while the access is incomplete
//   bus_err             one-cycle pulse, in DONE, on a nonzero rresp/bresp
//   ar*/r*/aw*/w*/b*    single-beat AXI-style master channels
module dsram_axi_bridge #(
    parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF,
    parameter logic [31:0] ERR_DATA  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        bus_err,
    output logic        arvalid,
    output logic [31:0] araddr,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    output logic        rready,
    output logic        awvalid,
    output logic [31:0] awaddr,
    input  logic        awready,
    output logic        wvalid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        wready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state_reg,   state_next;
    // Only the word address is kept. The byte offset never reaches the bus.
    logic [29:0] addr_reg,    addr_next;
    logic [3:0]  wen_reg,     wen_next;
    logic [31:0] wdata_reg,   wdata_next;
    logic [31:0] rd_data_reg, rd_data_next;
    logic        arvalid_reg, arvalid_next;
    logic        rready_reg,  rready_next;
    logic        awvalid_reg, awvalid_next;
    logic        wvalid_reg,  wvalid_next;
    logic        bready_reg,  bready_next;
    logic        bus_err_reg, bus_err_next;

    // A write channel counts as finished if it completed earlier
    // (its valid is already low) or if it handshakes in this cycle.
    logic aw_done;
    logic w_done;

    assign aw_done = !awvalid_reg || awready;
    assign w_done  = !wvalid_reg  || wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            wen_reg     <= '0;
            wdata_reg   <= '0;
            rd_data_reg <= '0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            wen_reg     <= wen_next;
            wdata_reg   <= wdata_next;
            rd_data_reg <= rd_data_next;
            arvalid_reg <= arvalid_next;
            rready_reg  <= rready_next;
            awvalid_reg <= awvalid_next;
            wvalid_reg  <= wvalid_next;
            bready_reg  <= bready_next;
            bus_err_reg <= bus_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        wen_next     = wen_reg;
        wdata_next   = wdata_reg;
        rd_data_next = rd_data_reg;
        arvalid_next = arvalid_reg;
        rready_next  = rready_reg;
        awvalid_next = awvalid_reg;
        wvalid_next  = wvalid_reg;
        bready_next  = bready_reg;
        // bus_err is a pulse. It is set only on the transition into DONE.
        bus_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (data_sram_en) begin
                    addr_next = data_sram_addr[31:2] & ADDR_MASK[31:2];
                    if (data_sram_wen == 4'b0000) begin
                        arvalid_next = 1'b1;
                        state_next   = RD_ADDR;
                    end else begin
                        wen_next     = data_sram_wen;
                        wdata_next   = data_sram_wdata;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = WR_REQ;
                    end
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    rready_next  = 1'b0;
                    rd_data_next = (rresp == 2'b00) ? rdata : ERR_DATA;
                    bus_err_next = (rresp != 2'b00);
                    state_next   = DONE;
                end
            end
            WR_REQ: begin
                if (awvalid_reg && awready) begin
                    awvalid_next = 1'b0;
                end
                if (wvalid_reg && wready) begin
                    wvalid_next = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_next = 1'b1;
                    state_next  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    bready_next  = 1'b0;
                    bus_err_next = (bresp != 2'b00);
                    state_next   = DONE;
                end
            end
            DONE: begin
                // The core still presents the finished request in this cycle,
                // so en is deliberately not looked at here.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign stallreq = ((state_reg == IDLE) && data_sram_en) ||
                      (state_reg == RD_ADDR) || (state_reg == RD_DATA) ||
                      (state_reg == WR_REQ)  || (state_reg == WR_RESP);

    assign araddr          = {addr_reg, 2'b00};
    assign awaddr          = {addr_reg, 2'b00};
    assign wdata           = wdata_reg;
    assign wstrb           = wen_reg;
    assign arvalid         = arvalid_reg;
    assign rready          = rready_reg;
    assign awvalid         = awvalid_reg;
    assign wvalid          = wvalid_reg;
    assign bready          = bready_reg;
    assign bus_err         = bus_err_reg;
    assign data_sram_rdata = rd_data_reg;

endmodule
